aes_arbiter: RTL and testbench

AES_ARBITER -- requirements
Module: aes_arbiter

---
 rtl/aes_arb_pkg.sv | 17 +
 rtl/aes_rr_picker.sv | 24 ++
 rtl/aes_arbiter.sv | 127 ++++++++++++
 tb/tb_aes_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the two-requester AES engine arbiter.
package aes_arb_pkg;

  localparam int AES_W = 128;
  localparam int TIMEOUT_CYCLES_DEF = 512;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } arb_state_t;

endpackage

// File: rtl/aes_rr_picker.sv
// Two-way round-robin picker: one-hot grant from pending requests
// and the id of the most recently served requester.
module aes_rr_picker
  import aes_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): begin
        if (last == REQ_ID0) grant[REQ_ID1] = 1'b1;
        else                 grant[REQ_ID0] = 1'b1;
      end
      (req == 2'b01): grant[REQ_ID0] = 1'b1;
      (req == 2'b10): grant[REQ_ID1] = 1'b1;
      default:        grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/aes_arbiter.sv
// Arbitrates two requesters onto one shared AES engine.
// Define AES_ARB_TIMEOUT_EN to add the RUN watchdog and the err port.
module aes_arbiter
  import aes_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [AES_W-1:0] data0,
  input  logic [AES_W-1:0] data1,
  input  logic [AES_W-1:0] key0,
  input  logic [AES_W-1:0] key1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [AES_W-1:0] result,
  output logic             busy,
  output logic [AES_W-1:0] eng_data,
  output logic [AES_W-1:0] eng_key,
  output logic             eng_rst,
  input  logic             eng_ready,
  input  logic [AES_W-1:0] eng_out
`ifdef AES_ARB_TIMEOUT_EN
  ,
  output logic             err
`endif
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("aes_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t state;
  logic       last;
  logic       gid;
  logic [1:0] grant;

  aes_rr_picker u_pick (
    .req   ({req1, req0}),
    .last  (last),
    .grant (grant)
  );

  // Ack is the grant itself, so it lands in the IDLE cycle that captures.
  assign ack0 = (state == S_IDLE) & grant[REQ_ID0];
  assign ack1 = (state == S_IDLE) & grant[REQ_ID1];

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      last     <= REQ_ID1;
      gid      <= REQ_ID0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
      eng_data <= '0;
      eng_key  <= '0;
      eng_rst  <= 1'b1;
`ifdef AES_ARB_TIMEOUT_EN
      cnt      <= '0;
      err      <= 1'b0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
      err   <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          eng_rst <= |grant;
          if (|grant) begin
            gid      <= grant[REQ_ID1];
            eng_data <= grant[REQ_ID1] ? data1 : data0;
            eng_key  <= grant[REQ_ID1] ? key1 : key0;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          eng_rst <= 1'b0;
          state   <= S_RUN;
`ifdef AES_ARB_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        S_RUN: begin
          if (eng_ready) begin
            result <= eng_out;
            done0  <= (gid == REQ_ID0);
            done1  <= (gid == REQ_ID1);
            state  <= S_DONE;
          end
`ifdef AES_ARB_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            result <= '0;
            err    <= 1'b1;
            done0  <= (gid == REQ_ID0);
            done1  <= (gid == REQ_ID1);
            state  <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        S_DONE: begin
          last  <= gid;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_arbiter.sv
// Scoreboard bench for aes_arbiter with a stub AES engine.
module tb_aes_arbiter;

  localparam int TO = 40;
  localparam logic [127:0] V_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [127:0] data0 = '0, data1 = '0, key0 = '0, key1 = '0;
  logic         ack0, ack1, done0, done1, busy, eng_rst;
  logic [127:0] result, eng_data, eng_key;
  logic         eng_ready = 1'b0;
  logic [127:0] eng_out = '0;
`ifdef AES_ARB_TIMEOUT_EN
  logic         err;
`endif

  always #5 clk = ~clk;

  aes_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .key0      (key0),
    .key1      (key1),
    .ack0      (ack0),
    .ack1      (ack1),
    .done0     (done0),
    .done1     (done1),
    .result    (result),
    .busy      (busy),
    .eng_data  (eng_data),
    .eng_key   (eng_key),
    .eng_rst   (eng_rst),
    .eng_ready (eng_ready),
    .eng_out   (eng_out)
`ifdef AES_ARB_TIMEOUT_EN
    ,
    .err       (err)
`endif
  );

  typedef struct {
    logic [127:0] d;
    logic [127:0] k;
    logic [127:0] r;
    logic         e;
  } exp_t;

  typedef struct {
    logic [127:0] d;
    logic [127:0] k;
  } cmd_t;

  exp_t exp_q0[$], exp_q1[$];
  cmd_t cmd_q0[$], cmd_q1[$];
  int   grant_log[$], ack_cyc[$], done_cyc[$];

  int checks = 0;
  int passes = 0;
  logic stall = 1'b0;
  int lat_lo = 0, lat_hi = 5;

  function automatic logic [127:0] mock(input logic [127:0] d, input logic [127:0] k);
    if (d == V_PT && k == V_KEY) return V_CT;
    return {d[63:0], d[127:64]} ^ k ^ 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Stub engine: restarts on eng_rst, raises a ready level after a random delay.
  int e_cnt = 0;
  always @(posedge clk) begin
    if (eng_rst) begin
      e_cnt     <= $urandom_range(lat_lo, lat_hi);
      eng_ready <= 1'b0;
    end else if (!stall && !eng_ready) begin
      if (e_cnt == 0) begin
        eng_ready <= 1'b1;
        eng_out   <= mock(eng_data, eng_key);
      end else begin
        e_cnt <= e_cnt - 1;
      end
    end
  end

  task automatic drive(input bit id);
    cmd_t c;
    exp_t e;
    int   n;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) continue;
      if ((id ? cmd_q1.size() : cmd_q0.size()) == 0) continue;
      c = id ? cmd_q1.pop_front() : cmd_q0.pop_front();
      e.d = c.d;
      e.k = c.k;
      e.r = stall ? '0 : mock(c.d, c.k);
      e.e = stall;
      if (id) begin
        exp_q1.push_back(e);
        data1 = c.d; key1 = c.k; req1 = 1'b1;
      end else begin
        exp_q0.push_back(e);
        data0 = c.d; key0 = c.k; req0 = 1'b1;
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(id ? ack1 : ack0) && rst && n < 3000);
      if (!(id ? ack1 : ack0)) begin
        checks++;
        $display("FAIL ack_wait%0d: no ack after %0d cycles", id, n);
      end
      // Drop the request and scramble operands right after the grant.
      @(posedge clk);
      #1;
      if (id) begin
        req1 = 1'b0; data1 = rand128(); key1 = rand128();
      end else begin
        req0 = 1'b0; data0 = rand128(); key0 = rand128();
      end
    end
  endtask

  initial drive(1'b0);
  initial drive(1'b1);

  bit   trk = 1'b0;
  int   t = 0, w = 0, cyc = 0, done_cnt = 0;
  logic last_m = 1'b1;
  logic cur_id = 1'b0;
  logic mid;
  exp_t cur, pe;

  always @(negedge clk) begin
    if (!rst) begin
      trk    = 1'b0;
      last_m = 1'b1;
    end else begin
      cyc++;
      if (trk) begin
        t++;
        if (!eng_rst && !eng_ready && !done0 && !done1) w++;
        if (t == 1) begin
          check("load_eng_rst", eng_rst, 1);
          check("load_busy", busy, 1);
          check("eng_data", eng_data, cur.d);
          check("eng_key", eng_key, cur.k);
        end
        if (t == 2) check("run_eng_rst", eng_rst, 0);
      end
      if (done0 || done1) begin
        done_cnt++;
        check("done_excl", done0 && done1, 0);
        mid = done1;
        if ((mid ? exp_q1.size() : exp_q0.size()) == 0) begin
          checks++;
          $display("FAIL done_unexpected%0d: done with nothing outstanding", mid);
        end else begin
          pe = mid ? exp_q1.pop_front() : exp_q0.pop_front();
          check("result", result, pe.r);
          check("turnaround", t, pe.e ? w + 2 : w + 3);
`ifdef AES_ARB_TIMEOUT_EN
          check("err", err, pe.e);
          if (pe.e) check("timeout_len", w, TO);
`endif
          if (trk) check("done_id", mid, cur_id);
        end
        last_m = mid;
        trk    = 1'b0;
        done_cyc.push_back(cyc);
      end
      if (ack0 || ack1) begin
        check("ack_excl", ack0 && ack1, 0);
        mid = ack1;
        if (req0 && req1) check("rr_grant", mid, !last_m);
        if ((mid ? exp_q1.size() : exp_q0.size()) != 0)
          cur = mid ? exp_q1[$] : exp_q0[$];
        trk    = 1'b1;
        t      = 0;
        w      = 0;
        cur_id = mid;
        grant_log.push_back(int'(mid));
        ack_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk_reset();
    check("rst_busy", busy, 0);
    check("rst_ack", {ack1, ack0}, 0);
    check("rst_done", {done1, done0}, 0);
    check("rst_result", result, 0);
    check("rst_eng_data", eng_data, 0);
    check("rst_eng_key", eng_key, 0);
    check("rst_eng_rst", eng_rst, 1);
`ifdef AES_ARB_TIMEOUT_EN
    check("rst_err", err, 0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    repeat (3) @(negedge clk);
    chk_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    grant_log.delete();
    ack_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 5000 && (cmd_q0.size() + cmd_q1.size() + exp_q0.size() +
                            exp_q1.size() != 0 || busy || req0 || req1));
    check("drain", n < 5000, 1);
  endtask

  task automatic push(input bit id, input logic [127:0] d, input logic [127:0] k);
    cmd_t c;
    c.d = d;
    c.k = k;
    if (id) cmd_q1.push_back(c);
    else    cmd_q0.push_back(c);
  endtask

  int n;
  int r;

  initial begin
    do_reset();

    // Known-answer block on requester 0.
    @(negedge clk);
    push(0, V_PT, V_KEY);
    wait_idle();
    check("kat_grants", grant_log.size(), 1);

    // Simultaneous requests after reset, then again.
    do_reset();
    @(negedge clk);
    push(0, rand128(), rand128());
    push(1, rand128(), rand128());
    wait_idle();
    @(negedge clk);
    push(0, rand128(), rand128());
    push(1, rand128(), rand128());
    wait_idle();
    check("sim_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check("sim_first", grant_log[0], 0);
      check("sim_second", grant_log[1], 1);
      check("sim_alt", grant_log[2], int'(!grant_log[1][0]));
    end

    // Requester 1 arrives while requester 0 is running.
    grant_log.delete();
    ack_cyc.delete();
    done_cyc.delete();
    lat_lo = 8;
    lat_hi = 8;
    @(negedge clk);
    push(0, rand128(), rand128());
    n = 0;
    do begin @(negedge clk); n++; end while (!ack0 && n < 100);
    repeat (2) @(negedge clk);
    push(1, rand128(), rand128());
    wait_idle();
    check("busy_count", grant_log.size(), 2);
    if (grant_log.size() == 2 && done_cyc.size() >= 1)
      check("ack1_after_done0", ack_cyc[1], done_cyc[0] + 1);

    // Reset in the middle of RUN aborts the block.
    lat_lo = 20;
    lat_hi = 20;
    @(negedge clk);
    push(0, rand128(), rand128());
    n = 0;
    do begin @(negedge clk); n++; end while (!ack0 && n < 100);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    chk_reset();
    r = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt, r);
    lat_lo = 0;
    lat_hi = 5;
    push(0, rand128(), rand128());
    wait_idle();

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 2);
      lat_hi = $urandom_range(0, 8);
      @(negedge clk);
      if (r != 1) push(0, rand128(), rand128());
      if (r != 0) push(1, rand128(), rand128());
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end
    wait_idle();

`ifdef AES_ARB_TIMEOUT_EN
    // Engine never completes: watchdog ends the block with err.
    @(negedge clk);
    stall = 1'b1;
    push(0, rand128(), rand128());
    wait_idle();
    stall = 1'b0;
    @(negedge clk);
    push(1, rand128(), rand128());
    wait_idle();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
